div_sequencer: RTL and testbench



---
 rtl/div_sequencer_if.sv | 25 ++
 rtl/div_sequencer.sv | 166 ++++++++++++++++
 tb/tb_div_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Interface between the EXE stage and the divide sequencer.
// The master side (EXE stage) issues divide requests and pipeline controls.
// The slave side (div_sequencer) returns the stall, the done flag and the HI/LO results.
interface div_sequencer_if;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_opa;
  logic [31:0] div_opb;
  logic        flush;
  logic        accept;
  logic        div_stall;
  logic        div_done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  modport master (
    output div_req, div_signed, div_opa, div_opb, flush, accept,
    input  div_stall, div_done, div_hi, div_lo
  );

  modport slave (
    input  div_req, div_signed, div_opa, div_opb, flush, accept,
    output div_stall, div_done, div_hi, div_lo
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle MIPS DIV/DIVU sequencer for the EXE stage.
// It performs a 32-step restoring division on operand magnitudes and applies the sign
// fix-ups on the final step.
// div_stall is combinational, so the pipeline freezes in the same cycle the request is seen.
// div_done, div_hi and div_lo are registered.
// Optional feature macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
// reaches DONE one cycle after the request.
module div_sequencer #(
  parameter int unsigned ITER = 32
) (
  input  logic           clk,
  input  logic           resetn,
  div_sequencer_if.slave bus
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     dvd_q, dvd_d;     // dividend shifts out the top, quotient shifts in the bottom
  logic [W-1:0]     dvs_q, dvs_d;
  logic [W-1:0]     rem_q, rem_d;     // the 33rd remainder bit exists only after the shift
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             done_q, done_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic [W:0]       rem_sh;
  logic             q_bit;
  logic [W-1:0]     rem_nx;
  logic [W-1:0]     quot_nx;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;
  logic             req_q_neg;
  logic             req_r_neg;

  // Two's-complement negate when neg is set; wraps modulo 2^32.
  function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic neg);
    return neg ? W'(~v + W'(1)) : v;
  endfunction

  // Request-side operand magnitudes and result signs.
  always_comb begin
    a_mag     = neg_if(bus.div_opa, bus.div_signed & bus.div_opa[W-1]);
    b_mag     = neg_if(bus.div_opb, bus.div_signed & bus.div_opb[W-1]);
    req_q_neg = bus.div_signed & (bus.div_opa[W-1] ^ bus.div_opb[W-1]);
    req_r_neg = bus.div_signed & bus.div_opa[W-1];
  end

  // One restoring-division step.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[W-1]};
    q_bit   = (rem_sh >= {1'b0, dvs_q});
    rem_nx  = q_bit ? W'(rem_sh - {1'b0, dvs_q}) : W'(rem_sh);
    quot_nx = {dvd_q[W-2:0], q_bit};
  end

  // Next-state and datapath update; flush overrides everything.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    done_d  = done_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.div_req) begin
            state_d = S_BUSY;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            q_neg_d = req_q_neg;
            r_neg_d = req_r_neg;
            rem_d   = '0;
            cnt_d   = '0;
`ifdef DIV_ZERO_FAST_EN
            // The zero-divisor result equals what the iterations would produce.
            if (bus.div_opb == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              lo_d    = neg_if({W{1'b1}}, req_q_neg);
              hi_d    = neg_if(a_mag, req_r_neg);
            end
`endif
          end
        end
        S_BUSY: begin
          rem_d = rem_nx;
          dvd_d = quot_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            lo_d    = neg_if(quot_nx, q_neg_q);
            hi_d    = neg_if(rem_nx, r_neg_q);
          end
        end
        S_DONE: begin
          if (bus.accept) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Stall is gated by reset so every output reads zero while resetn is low.
  assign bus.div_stall = resetn &
                         (((state_q == S_IDLE) & bus.div_req & ~bus.flush) |
                          (state_q == S_BUSY));
  assign bus.div_done  = done_q;
  assign bus.div_hi    = hi_q;
  assign bus.div_lo    = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer.
module tb_div_sequencer;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_CYC = 1;
`else
  localparam int ZERO_CYC = 33;
`endif

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  div_sequencer_if bus ();

  div_sequencer #(.ITER(32)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a divide from IDLE, count stall cycles, then check the result.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_cyc);
    int cnt;
    bus.div_req    = 1'b1;
    bus.div_signed = sgn;
    bus.div_opa    = a;
    bus.div_opb    = b;
    bus.flush      = 1'b0;
    bus.accept     = 1'b0;
    #1;
    cnt = 0;
    while (bus.div_stall === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 32'(cnt), 32'(exp_cyc));
    chk({tag, "_done"}, 32'(bus.div_done), 32'd1);
    chk({tag, "_lo"}, bus.div_lo, exp_lo);
    chk({tag, "_hi"}, bus.div_hi, exp_hi);
  endtask

  // Retire the result and return to IDLE with no request pending.
  task automatic retire(input string tag);
    bus.accept  = 1'b1;
    bus.div_req = 1'b0;
    @(negedge clk);
    #1;
    bus.accept = 1'b0;
    chk({tag, "_done_cleared"}, 32'(bus.div_done), 32'd0);
  endtask

  initial begin
    int   seen_done;
    n_cmp          = 0;
    n_bad          = 0;
    resetn         = 1'b0;
    bus.div_req    = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_opa    = '0;
    bus.div_opb    = '0;
    bus.flush      = 1'b0;
    bus.accept     = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.div_stall), 32'd0);
    chk("rst_done", 32'(bus.div_done), 32'd0);
    chk("rst_hi", bus.div_hi, 32'd0);
    chk("rst_lo", bus.div_lo, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Basic unsigned and signed divides.
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    retire("divu_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    retire("div_m7_2");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
    retire("div_7_m2");
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    retire("div_ovf");
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
    retire("divu_max_1");

    // Divide by zero.
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZERO_CYC);
    retire("divu_5_0");
    run_div("div_m20_0", 1'b1, 32'hFFFF_FFEC, 32'd0, 32'd1, 32'hFFFF_FFEC, ZERO_CYC);
    retire("div_m20_0");

    // Flush at BUSY step 10.
    bus.div_req    = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_opa    = 32'd1000;
    bus.div_opb    = 32'd3;
    #1;
    chk("flush_cycle0_stall", 32'(bus.div_stall), 32'd1);
    repeat (11) @(negedge clk);
    #1;
    bus.flush   = 1'b1;
    bus.div_req = 1'b0;
    chk("flush_busy_stall", 32'(bus.div_stall), 32'd1);
    @(negedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_stall_drop", 32'(bus.div_stall), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.div_done === 1'b1) seen_done++;
      @(negedge clk);
      #1;
    end
    chk("flush_no_done", 32'(seen_done), 32'd0);
    run_div("after_flush", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

    // Hold in DONE without accept, request still high.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_done", 32'(bus.div_done), 32'd1);
      chk("hold_stall", 32'(bus.div_stall), 32'd0);
      chk("hold_lo", bus.div_lo, 32'd333);
      chk("hold_hi", bus.div_hi, 32'd1);
    end

    // Back-to-back: accept with the next divide already in EXE.
    bus.accept  = 1'b1;
    bus.div_opa = 32'hDEAD_BEEF;
    bus.div_opb = 32'h0000_1000;
    @(negedge clk);
    #1;
    bus.accept = 1'b0;
    chk("b2b_idle_done", 32'(bus.div_done), 32'd0);
    chk("b2b_idle_stall", 32'(bus.div_stall), 32'd1);
    run_div("b2b_second", 1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 32'h000D_EADB, 32'h0000_0EEF, 33);
    retire("b2b_second");

    // Reset at BUSY step 20.
    bus.div_req    = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_opa    = 32'd100;
    bus.div_opb    = 32'd7;
    repeat (21) @(negedge clk);
    #1;
    chk("prerst_stall", 32'(bus.div_stall), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrst_stall", 32'(bus.div_stall), 32'd0);
    chk("midrst_done", 32'(bus.div_done), 32'd0);
    chk("midrst_hi", bus.div_hi, 32'd0);
    chk("midrst_lo", bus.div_lo, 32'd0);
    bus.div_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    chk("postrst_stall", 32'(bus.div_stall), 32'd0);
    chk("postrst_done", 32'(bus.div_done), 32'd0);
    run_div("postrst_div", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    retire("postrst_div");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
